// File: rtl/led_matrix_refresh.sv
`default_nettype none
// ============================================================================
// Module      : led_matrix_refresh
// Description : Wishbone master that keeps a MAX7219-style 8x8 LED matrix
//               refreshed through the SPI peripheral. Optional per-row dirty
//               tracking is enabled with the macro LED_REFRESH_DIRTY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module led_matrix_refresh #(
  parameter int          REFRESH_CYCLES = 1000000,
  parameter logic [31:0] CS_ADR         = 32'h0600_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic        m_ack_i,
  output logic        busy,
  output logic        frame_done
);

  localparam int                 c_CNT_W  = $clog2(REFRESH_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(REFRESH_CYCLES);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_ROWS = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t             r_state, w_state_next;
  logic [7:0]         r_fb [8];
  logic [3:0]         r_intensity;
  logic               r_enable;
  logic               r_int_dirty;
  logic               r_int_done;
  logic [2:0]         r_init_idx;
  logic [3:0]         r_row_idx;
  logic               r_cyc;
  logic [15:0]        r_dat;
  logic               r_cur_int;
  logic [2:0]         r_cur_row;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_frame_done;
`ifdef LED_REFRESH_DIRTY_EN
  logic [7:0]         r_dirty;
`endif

  logic        w_ack;
  logic        w_wr_int;
  logic        w_row_found;
  logic [2:0]  w_row_sel;
  logic        w_send_int;
  logic        w_burst_has;
  logic [15:0] w_burst_word;
  logic [15:0] w_init_word;
  logic        w_start;
  logic [15:0] w_word;
  logic        w_word_is_int;
  logic        w_frame_done;
  logic        w_enter_init;
  logic        w_enter_wait;

  // Acks are only meaningful while our own cycle is open.
  assign w_ack    = r_cyc & m_ack_i;
  assign w_wr_int = wr_en && (wr_addr == 4'd8);

  always_comb begin
    w_row_found = 1'b0;
    w_row_sel   = 3'd0;
`ifdef LED_REFRESH_DIRTY_EN
    // Lowest dirty row at or above the burst position.
    for (int i = 7; i >= 0; i--) begin
      if (r_dirty[i] && (4'(i) >= r_row_idx)) begin
        w_row_found = 1'b1;
        w_row_sel   = 3'(i);
      end
    end
`else
    w_row_found = ~r_row_idx[3];
    w_row_sel   = r_row_idx[2:0];
`endif
  end

  assign w_send_int   = r_int_dirty & ~r_int_done;
  assign w_burst_has  = w_send_int | w_row_found;
  assign w_burst_word = w_send_int ? {8'h0A, 4'h0, r_intensity}
                                   : {4'h0, {1'b0, w_row_sel} + 4'd1, r_fb[w_row_sel]};

  always_comb begin
    case (r_init_idx)
      3'd0:    w_init_word = 16'h0C01;
      3'd1:    w_init_word = 16'h0900;
      3'd2:    w_init_word = 16'h0B07;
      3'd3:    w_init_word = 16'h0F00;
      default: w_init_word = {8'h0A, 4'h0, r_intensity};
    endcase
  end

  // Sequencing decisions are made only in cycles with no open transfer,
  // which also guarantees an idle cycle after every ack.
  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_word        = 16'h0000;
    w_word_is_int = 1'b0;
    w_frame_done  = 1'b0;
    w_enter_init  = 1'b0;
    w_enter_wait  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_enable) begin
          w_state_next = S_INIT;
          w_enter_init = 1'b1;
        end
      end
      S_INIT: begin
        if (!r_cyc) begin
          if (!r_enable) begin
            w_state_next = S_IDLE;
          end else if (r_init_idx < 3'd5) begin
            w_start = 1'b1;
            w_word  = w_init_word;
          end else begin
            w_state_next = S_ROWS;
          end
        end
      end
      S_ROWS: begin
        if (!r_cyc) begin
          if (!r_enable) begin
            w_state_next = S_IDLE;
          end else if (w_burst_has) begin
            w_start       = 1'b1;
            w_word        = w_burst_word;
            w_word_is_int = w_send_int;
          end else begin
            w_frame_done = 1'b1;
            w_state_next = S_WAIT;
            w_enter_wait = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!r_enable) begin
          w_state_next = S_IDLE;
        end else if (r_cnt <= c_ONE) begin
          // Launch the first word straight from WAIT so the period is exact.
          w_state_next  = S_ROWS;
          w_start       = w_burst_has;
          w_word        = w_burst_word;
          w_word_is_int = w_send_int;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      for (int i = 0; i < 8; i++) r_fb[i] <= 8'h00;
      r_intensity  <= 4'h0;
      r_enable     <= 1'b0;
      r_int_dirty  <= 1'b1;
      r_int_done   <= 1'b0;
      r_init_idx   <= 3'd0;
      r_row_idx    <= 4'd0;
      r_cyc        <= 1'b0;
      r_dat        <= 16'h0000;
      r_cur_int    <= 1'b0;
      r_cur_row    <= 3'd0;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
`ifdef LED_REFRESH_DIRTY_EN
      r_dirty      <= 8'hFF;
`endif
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= w_frame_done;

      if (w_start) begin
        r_cyc     <= 1'b1;
        r_dat     <= w_word;
        r_cur_int <= w_word_is_int;
        r_cur_row <= w_row_sel;
      end else if (w_ack) begin
        r_cyc <= 1'b0;
      end

      if (w_ack) begin
        if (r_state == S_INIT) begin
          r_init_idx <= r_init_idx + 3'd1;
          if (r_init_idx == 3'd4) r_int_dirty <= 1'b0;
        end else if (r_cur_int) begin
          r_int_dirty <= 1'b0;
          r_int_done  <= 1'b1;
        end else begin
          r_row_idx  <= {1'b0, r_cur_row} + 4'd1;
          r_int_done <= 1'b1;
`ifdef LED_REFRESH_DIRTY_EN
          r_dirty[r_cur_row] <= 1'b0;
`endif
        end
      end

      if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - c_ONE;

      if (w_enter_init) begin
        r_init_idx <= 3'd0;
        r_row_idx  <= 4'd0;
        r_int_done <= 1'b0;
`ifdef LED_REFRESH_DIRTY_EN
        r_dirty    <= 8'hFF;
`endif
      end
      if (w_enter_wait) begin
        r_cnt      <= c_RELOAD;
        r_row_idx  <= 4'd0;
        r_int_done <= 1'b0;
      end

      // Register port last: a write beats a same-cycle flag clear.
      if (wr_en) begin
        if (!wr_addr[3]) begin
          r_fb[wr_addr[2:0]] <= wr_data;
`ifdef LED_REFRESH_DIRTY_EN
          r_dirty[wr_addr[2:0]] <= 1'b1;
`endif
        end else if (w_wr_int) begin
          r_intensity <= wr_data[3:0];
          r_int_dirty <= 1'b1;
        end else if (wr_addr == 4'd9) begin
          r_enable <= wr_data[0];
        end
      end
    end
  end

  // Strobe is masked in any ack cycle so the slave never sees a repeat.
  assign m_cyc_o    = r_cyc & ~m_ack_i;
  assign m_stb_o    = r_cyc & ~m_ack_i;
  assign m_we_o     = m_cyc_o;
  assign m_adr_o    = CS_ADR;
  assign m_sel_o    = 4'b0011;
  assign m_dat_o    = {16'h0000, r_dat};
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
